// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and types used by the instruction prefetch path.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // FETCH_PEND: request on the bus, data will be queued.
    // FETCH_DISCARD: request on the bus, data will be dropped (redirected).
    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_PEND    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with flush; read data is zero while empty.
module riscv_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_prefetch.sv
// Instruction prefetcher: one outstanding bus request feeding a small queue,
// with branch redirect and discard of in-flight data.
module riscv_prefetch
    import riscv_pkg::*;
#(
    parameter int              FETCH_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         resetn,
    output logic [XLEN-1:0]              instr_bif_addr,
    output logic                         instr_bif_req,
    input  logic                         instr_bif_ack,
    input  logic [ILEN-1:0]              instr_bif_rdata,
    input  logic                         fetch_halt,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ILEN-1:0]              out_instr,
    output logic [XLEN-1:0]              out_pc,
    output logic [$clog2(FETCH_DEPTH):0] fetch_count,
    output fetch_state_e                 fetch_state
);

    localparam int CNT_W = $clog2(FETCH_DEPTH) + 1;

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] req_addr, req_addr_next;
    logic            can_issue;
    logic            push;
    logic            pop;
    logic            flush;
    logic [XLEN+ILEN-1:0] head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
        end
    end

    // Bus handshake: req rises with a stable addr and both stay put until the
    // ack cycle; ack may arrive in the very cycle req first rises.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        push          = 1'b0;
        flush         = 1'b0;
        can_issue     = resetn && (state == FETCH_IDLE) && !fetch_halt && !redirect_valid
                        && (fetch_count < CNT_W'(FETCH_DEPTH));
        instr_bif_req  = (state != FETCH_IDLE) || can_issue;
        instr_bif_addr = (state == FETCH_IDLE) ? pc : req_addr;

        if (redirect_valid) begin
            flush   = 1'b1;
            pc_next = word_align(redirect_target);
            if (state != FETCH_IDLE && !instr_bif_ack) begin
                state_next = FETCH_DISCARD;
            end else begin
                state_next = FETCH_IDLE;
            end
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (can_issue) begin
                        if (instr_bif_ack) begin
                            push    = 1'b1;
                            pc_next = pc + XLEN'(4);
                        end else begin
                            state_next    = FETCH_PEND;
                            req_addr_next = pc;
                        end
                    end
                end
                FETCH_PEND: begin
                    if (instr_bif_ack) begin
                        push       = 1'b1;
                        pc_next    = req_addr + XLEN'(4);
                        state_next = FETCH_IDLE;
                    end
                end
                FETCH_DISCARD: begin
                    if (instr_bif_ack) begin
                        state_next = FETCH_IDLE;
                    end
                end
                default: state_next = FETCH_IDLE;
            endcase
        end
    end

    assign out_valid   = (fetch_count != '0);
    assign pop         = out_valid && out_ready && !redirect_valid;
    assign out_pc      = head[XLEN+ILEN-1:ILEN];
    assign out_instr   = head[ILEN-1:0];
    assign fetch_state = state;

    riscv_sync_fifo #(
        .WIDTH(XLEN + ILEN),
        .DEPTH(FETCH_DEPTH)
    ) u_queue (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .push   (push),
        .wr_data({instr_bif_addr, instr_bif_rdata}),
        .pop    (pop),
        .rd_data(head),
        .count  (fetch_count)
    );

endmodule

// File: tb/tb_riscv_prefetch.sv
// Directed bench for riscv_prefetch: streaming, queue full, redirects, halt and PC wrap.
module tb_riscv_prefetch;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  instr_bif_addr;
    logic         instr_bif_req;
    logic         instr_bif_ack = 1'b0;
    logic [31:0]  instr_bif_rdata = '0;
    logic         fetch_halt = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_target = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;
    logic [2:0]   fetch_count;
    fetch_state_e fetch_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_prefetch #(
        .FETCH_DEPTH(DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .instr_bif_addr (instr_bif_addr),
        .instr_bif_req  (instr_bif_req),
        .instr_bif_ack  (instr_bif_ack),
        .instr_bif_rdata(instr_bif_rdata),
        .fetch_halt     (fetch_halt),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_count    (fetch_count),
        .fetch_state    (fetch_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Applies one cycle's inputs just after a falling edge, then settles.
    task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                         input logic halt, input logic redir, input logic [31:0] tgt);
        instr_bif_ack   = ack;
        instr_bif_rdata = rdata;
        out_ready       = ready;
        fetch_halt      = halt;
        redirect_valid  = redir;
        redirect_target = tgt;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        check_eq("rst_req", 32'(instr_bif_req), 32'd0);
        check_eq("rst_addr", instr_bif_addr, 32'h0000_0000);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(fetch_count), 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        // Streaming: ack every cycle, decode always ready.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, word_of(32'(4 * k)), 1'b1, 1'b0, 1'b0, '0);
            check_eq("s1_req", 32'(instr_bif_req), 32'd1);
            check_eq("s1_addr", instr_bif_addr, 32'(4 * k));
            check_eq("s1_valid", 32'(out_valid), (k > 0) ? 32'd1 : 32'd0);
            if (k > 0) begin
                check_eq("s1_out_pc", out_pc, 32'(4 * (k - 1)));
                check_eq("s1_out_instr", out_instr, word_of(32'(4 * (k - 1))));
                check_eq("s1_count", 32'(fetch_count), 32'd1);
            end
            tick();
        end

        // Queue fills to DEPTH with decode stalled.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1'b1, word_of(32'(4 * k)), 1'b0, 1'b0, 1'b0, '0);
            check_eq("s2_addr", instr_bif_addr, 32'(4 * k));
            check_eq("s2_count", 32'(fetch_count), 32'(k));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
            check_eq("s2_full_req", 32'(instr_bif_req), 32'd0);
            check_eq("s2_full_count", 32'(fetch_count), 32'd4);
            check_eq("s2_head_pc", out_pc, 32'd0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s2_pop_req", 32'(instr_bif_req), 32'd0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("s2_after_pop_count", 32'(fetch_count), 32'd3);
        check_eq("s2_after_pop_req", 32'(instr_bif_req), 32'd1);
        check_eq("s2_after_pop_addr", instr_bif_addr, 32'd16);
        check_eq("s2_after_pop_pc", out_pc, 32'd4);

        // Redirect while 0x8 pending; its ack arrives three cycles later.
        do_reset();
        drive(1'b1, word_of(32'h0), 1'b1, 1'b0, 1'b0, '0);
        check_eq("s3_addr0", instr_bif_addr, 32'h0);
        tick();
        drive(1'b1, word_of(32'h4), 1'b1, 1'b0, 1'b0, '0);
        check_eq("s3_addr4", instr_bif_addr, 32'h4);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s3_addr8", instr_bif_addr, 32'h8);
        check_eq("s3_head4", out_pc, 32'h4);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h0000_1003);
        check_eq("s3_redir_req", 32'(instr_bif_req), 32'd1);
        check_eq("s3_redir_addr", instr_bif_addr, 32'h8);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
            check_eq("s3_hold_addr", instr_bif_addr, 32'h8);
            check_eq("s3_hold_req", 32'(instr_bif_req), 32'd1);
            check_eq("s3_hold_valid", 32'(out_valid), 32'd0);
            check_eq("s3_state", 32'(fetch_state), 32'(FETCH_DISCARD));
            tick();
        end
        drive(1'b1, word_of(32'h8), 1'b1, 1'b0, 1'b0, '0);
        check_eq("s3_stale_addr", instr_bif_addr, 32'h8);
        tick();
        drive(1'b1, word_of(32'h1000), 1'b1, 1'b0, 1'b0, '0);
        check_eq("s3_target_addr", instr_bif_addr, 32'h0000_1000);
        check_eq("s3_target_req", 32'(instr_bif_req), 32'd1);
        check_eq("s3_dropped_valid", 32'(out_valid), 32'd0);
        check_eq("s3_dropped_count", 32'(fetch_count), 32'd0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s3_new_valid", 32'(out_valid), 32'd1);
        check_eq("s3_new_pc", out_pc, 32'h0000_1000);
        check_eq("s3_new_instr", out_instr, word_of(32'h1000));
        check_eq("s3_next_addr", instr_bif_addr, 32'h0000_1004);

        // Redirect coinciding with ack and a pop.
        do_reset();
        drive(1'b1, word_of(32'h0), 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("s4_count1", 32'(fetch_count), 32'd1);
        check_eq("s4_addr4", instr_bif_addr, 32'h4);
        tick();
        drive(1'b1, word_of(32'h4), 1'b1, 1'b0, 1'b1, 32'h0000_2000);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s4_count0", 32'(fetch_count), 32'd0);
        check_eq("s4_valid", 32'(out_valid), 32'd0);
        check_eq("s4_req", 32'(instr_bif_req), 32'd1);
        check_eq("s4_addr", instr_bif_addr, 32'h0000_2000);

        // Halt raised while a request is pending.
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("s5_req0", 32'(instr_bif_req), 32'd1);
        tick();
        drive(1'b1, word_of(32'h0), 1'b0, 1'b1, 1'b0, '0);
        check_eq("s5_pend_req", 32'(instr_bif_req), 32'd1);
        check_eq("s5_pend_addr", instr_bif_addr, 32'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
            check_eq("s5_halt_req", 32'(instr_bif_req), 32'd0);
            check_eq("s5_halt_count", 32'(fetch_count), 32'd1);
            check_eq("s5_halt_pc", out_pc, 32'h0);
            check_eq("s5_halt_instr", out_instr, word_of(32'h0));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        check_eq("s5_resume_req", 32'(instr_bif_req), 32'd1);
        check_eq("s5_resume_addr", instr_bif_addr, 32'h4);

        // PC wrap from the top word.
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check_eq("s6_redir_req", 32'(instr_bif_req), 32'd0);
        tick();
        drive(1'b1, word_of(32'hFFFF_FFFC), 1'b1, 1'b0, 1'b0, '0);
        check_eq("s6_top_addr", instr_bif_addr, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        check_eq("s6_wrap_addr", instr_bif_addr, 32'h0000_0000);
        check_eq("s6_wrap_req", 32'(instr_bif_req), 32'd1);
        check_eq("s6_top_pc", out_pc, 32'hFFFF_FFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_prefetch.md
RISCV_PREFETCH -- requirements
Module: riscv_prefetch

Interface
REQ-001 SHALL have parameter FETCH_DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] zero.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port instr_bif_addr, output, 32, word-aligned fetch address.
REQ-007 SHALL have port instr_bif_req, output, 1, fetch request.
REQ-008 SHALL have port instr_bif_ack, input, 1, single-cycle completion of the current request.
REQ-009 SHALL have port instr_bif_rdata, input, 32, instruction word, valid in the instr_bif_ack cycle.
REQ-010 SHALL have port fetch_halt, input, 1, blocks new requests without aborting a pending one.
REQ-011 SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-012 SHALL have port redirect_target, input, 32, redirect address; bits [1:0] ignored (forced zero).
REQ-013 SHALL have port out_valid, output, 1, queue head valid.
REQ-014 SHALL have port out_ready, input, 1, decode accepts head.
REQ-015 SHALL have port out_instr, output, 32, head instruction.
REQ-016 SHALL have port out_pc, output, 32, head instruction address.
REQ-017 SHALL have port fetch_count, output, $clog2(FETCH_DEPTH)+1, queue occupancy.

Function
REQ-018 SHALL assert instr_bif_req when no request is pending, fetch_halt=0, redirect_valid=0 and fetch_count + pending < FETCH_DEPTH; slot reserved at issue, so an ack never finds the queue full.
REQ-019 SHALL hold instr_bif_req high and instr_bif_addr stable from issue until the instr_bif_ack cycle, regardless of halt or redirect.
REQ-020 SHALL allow one outstanding request; a new request may be presented in the cycle after ack (peak 1 word/cycle when ack is combinational-ready).
REQ-021 SHALL, on ack with discard clear, push {instr_bif_addr, instr_bif_rdata} and advance the fetch PC by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-022 SHALL drive out_valid = (fetch_count != 0) and out_instr/out_pc from the head; pop on out_valid && out_ready.
REQ-023 SHALL handle simultaneous push and pop with fetch_count unchanged.
REQ-024 SHALL, on redirect_valid, empty the queue, ignore any same-cycle pop/push and load the fetch PC with {redirect_target[31:2],2'b00}; redirect has priority over all other events.
REQ-025 SHALL, if redirect_valid occurs with a request pending and no ack that cycle, set a discard flag; the matching ack's data is dropped and the flag cleared; the target is requested from the following cycle.
REQ-026 SHALL, if redirect_valid coincides with ack, drop that data with no discard flag set.
REQ-027 SHALL treat a second redirect while discard is set as replacing the target; only one ack is dropped.
REQ-028 SHALL present out_valid no earlier than the cycle after the ack that filled it (1-cycle fill latency).

Reset
REQ-029 SHALL, while resetn=0: instr_bif_req=0, instr_bif_addr=RESET_PC, out_valid=0, fetch_count=0, discard=0, pending=0; out_instr/out_pc are 0.
REQ-030 SHALL issue the first request to RESET_PC in the first cycle after resetn deasserts (fetch_halt=0).
REQ-031 SHALL, on reset mid-request, forget the pending request; a stale ack after reset is not possible by system contract.

Structure
REQ-032 SHALL take XLEN (32), the instruction-width and NOP (32'h0000_0013) constants from the shared riscv_pkg package; RESET_PC default also defined there.
REQ-033 SHALL implement the queue as one sub-module riscv_sync_fifo (parametrised width/depth, flush, push, pop, count); fetch control stays in riscv_prefetch.

Verification
REQ-034 SHALL check: reset release, ack every cycle, out_ready=1 -> addresses 0,4,8,... issued; out_pc follows same sequence one cycle after each ack.
REQ-035 SHALL check: out_ready=0, FETCH_DEPTH=4 -> exactly 4 acks accepted, fetch_count=4, instr_bif_req stays 0 until first pop.
REQ-036 SHALL check: redirect to 32'h0000_1003 while request to 0x8 pending, ack 3 cycles later -> 0x8 data dropped, next request address 0x1000, queue empty until it returns.
REQ-037 SHALL check: redirect coinciding with ack and out_ready -> no push, no pop, fetch_count=0, next address = target.
REQ-038 SHALL check: fetch_halt=1 while request pending -> request completes and is queued, no new request until halt drops.
REQ-039 SHALL check: PC at 32'hFFFF_FFFC acked -> next request address 32'h0000_0000.
